// File: rtl/dma_pkg.sv
// ============================================================================
// Module   : dma_pkg
// Purpose  : Shared constants and types for the byte-wide DMA RAM engine.
//            Provides default address/data widths, byte and address
//            typedefs, and the per-channel IDLE/ACTIVE state encoding.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dma_pkg;

  // Default geometry: 64 KiB of byte-addressable storage.
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  typedef logic [DEF_ADDR_W-1:0] dma_addr_t;
  typedef logic [DEF_DATA_W-1:0] dma_byte_t;

  // Per-channel completion state. ACTIVE means a request was accepted on
  // the previous edge, so the matching done strobe is high this cycle.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage : dma_pkg

`default_nettype wire

// File: rtl/dma_byte_ram.sv
// ============================================================================
// Module   : dma_byte_ram
// Purpose  : Synchronous byte RAM, one write port and one read port sharing
//            a clock. A read and a write to the same address on the same
//            edge return the pre-write byte (read-before-write).
// Ports    : clk    - system clock, rising edge
//            rst    - synchronous active-high reset (read register only;
//                     the array contents are never cleared)
//            we     - write enable
//            waddr  - write byte address
//            wdata  - write byte
//            re     - read enable
//            raddr  - read byte address
//            rdata  - registered read byte, holds until next read / reset
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dma_byte_ram
  import dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // The array has no reset so it maps onto block RAM; keeping the write in
  // its own process leaves the array free of any reset term.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Both processes sample the array before the edge's updates land, which
  // is what yields the old byte on a same-address read/write collision.
  // The read register resets to zero, matching a RAM output-register reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule : dma_byte_ram

`default_nettype wire

// File: rtl/dma_controller.sv
// ============================================================================
// Module   : dma_controller
// Purpose  : Byte-wide RAM access engine placed between the file_handler
//            front end and the image buffer. Accepts one read and one write
//            request per clock and returns a completion strobe for each one
//            cycle after acceptance.
// Ports    : clk        - system clock, rising edge
//            RST        - synchronous active-high reset
//            address    - byte address of the current request
//            data_in    - byte to write
//            read       - read request, level-sampled every rising edge
//            write      - write request, level-sampled every rising edge
//            data_out   - registered read data, valid with done_read
//            done_read  - read completion strobe
//            done_write - write completion strobe
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dma_controller
  import dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] data_out,
  output logic              done_read,
  output logic              done_write
);

  // --------------------------------------------------------------------------
  // Request qualification
  // --------------------------------------------------------------------------
  // A request counts only when its line is a clean 1 and reset is low. In a
  // four-state simulation an X/Z line makes these terms unknown, which the
  // RAM enable and state logic then treat as "not taken".
  logic wr_accept;
  logic rd_accept;

  assign wr_accept = (write == 1'b1) && (RST == 1'b0);
  assign rd_accept = (read  == 1'b1) && (RST == 1'b0);

  // --------------------------------------------------------------------------
  // Storage. The request is applied straight to the RAM on the accepting
  // edge so that data_out lands together with done_read one cycle later.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] ram_rdata;

  dma_byte_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .rst   (RST),
    .we    (wr_accept),
    .waddr (address),
    .wdata (data_in),
    .re    (rd_accept),
    .raddr (address),
    .rdata (ram_rdata)
  );

  // --------------------------------------------------------------------------
  // Per-channel IDLE/ACTIVE state. ACTIVE for exactly the cycle after each
  // accepted request, so a held request line keeps the strobe high
  // continuously and the strobe drops one cycle after the line drops.
  // --------------------------------------------------------------------------
  logic [0:0] wr_state_q, wr_state_d;
  logic [0:0] rd_state_q, rd_state_d;

  always_comb begin
    wr_state_d = ST_IDLE;
    rd_state_d = ST_IDLE;
    if (wr_accept) begin
      wr_state_d = ST_ACTIVE;
    end
    if (rd_accept) begin
      rd_state_d = ST_ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      wr_state_q <= ST_IDLE;
      rd_state_q <= ST_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
    end
  end

  assign done_write = (wr_state_q == ST_ACTIVE);
  assign done_read  = (rd_state_q == ST_ACTIVE);
  assign data_out   = ram_rdata;

endmodule : dma_controller

`default_nettype wire

// File: tb/tb_dma_controller.sv
// ============================================================================
// Module   : tb_dma_controller
// Purpose  : Directed self-checking bench for dma_controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dma_controller;

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic        read;
  logic        write;
  logic [7:0]  data_out;
  logic        done_read;
  logic        done_write;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dma_controller #(
    .ADDR_W (16),
    .DATA_W (8)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .address    (address),
    .data_in    (data_in),
    .read       (read),
    .write      (write),
    .data_out   (data_out),
    .done_read  (done_read),
    .done_write (done_write)
  );

  // Advance past the next rising edge and settle before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; address = '0; data_in = '0; read = 1'b0; write = 1'b0;
    tick(); tick();
    chk("rst_data_out",   data_out,          8'h00);
    chk("rst_done_read",  {7'd0, done_read}, 8'h00);
    chk("rst_done_write", {7'd0, done_write},8'h00);
    RST = 1'b0;

    // Preload known contents for the reset and reset-mid-burst checks.
    write = 1'b1; address = 16'h0010; data_in = 8'h3C;
    tick();
    chk("preload_dw", {7'd0, done_write}, 8'h01);
    address = 16'h3001; data_in = 8'hC3;
    tick();
    write = 1'b0;

    // Reset held 2 cycles with a write pending: nothing accepted.
    RST = 1'b1; write = 1'b1; address = 16'h0010; data_in = 8'hAA;
    tick();
    chk("rst1_dw", {7'd0, done_write}, 8'h00);
    chk("rst1_dr", {7'd0, done_read},  8'h00);
    tick();
    chk("rst2_dw", {7'd0, done_write}, 8'h00);
    chk("rst2_dr", {7'd0, done_read},  8'h00);
    RST = 1'b0; write = 1'b0;
    tick();
    chk("post_rst_dw", {7'd0, done_write}, 8'h00);
    read = 1'b1; address = 16'h0010;
    tick();
    chk("rst_keep_dr",   {7'd0, done_read}, 8'h01);
    chk("rst_keep_data", data_out,          8'h3C);
    read = 1'b0;

    // Single write then read.
    write = 1'b1; address = 16'h0100; data_in = 8'h5C;
    tick();
    chk("single_dw_hi", {7'd0, done_write}, 8'h01);
    write = 1'b0;
    tick();
    chk("single_dw_lo", {7'd0, done_write}, 8'h00);
    read = 1'b1; address = 16'h0100;
    tick();
    chk("single_dr_hi", {7'd0, done_read}, 8'h01);
    chk("single_data",  data_out,          8'h5C);
    read = 1'b0;
    tick();
    chk("single_dr_lo", {7'd0, done_read}, 8'h00);
    chk("single_hold",  data_out,          8'h5C);

    // Back-to-back byte pair, write held high.
    write = 1'b1; address = 16'h2000; data_in = 8'h12;
    tick();
    chk("pair_dw1", {7'd0, done_write}, 8'h01);
    address = 16'h2001; data_in = 8'h34;
    tick();
    chk("pair_dw2", {7'd0, done_write}, 8'h01);
    write = 1'b0;
    tick();
    chk("pair_dw3", {7'd0, done_write}, 8'h00);
    read = 1'b1; address = 16'h2000;
    tick();
    chk("pair_rd_hi", data_out, 8'h12);
    address = 16'h2001;
    tick();
    chk("pair_rd_lo", data_out,          8'h34);
    chk("pair_dr",    {7'd0, done_read}, 8'h01);
    read = 1'b0;

    // Simultaneous read/write to one address: read-before-write.
    write = 1'b1; address = 16'h0050; data_in = 8'h01;
    tick();
    data_in = 8'hFF; read = 1'b1;
    tick();
    chk("rw_old_data", data_out,           8'h01);
    chk("rw_dr",       {7'd0, done_read},  8'h01);
    chk("rw_dw",       {7'd0, done_write}, 8'h01);
    write = 1'b0;
    tick();
    chk("rw_new_data", data_out,           8'hFF);
    chk("rw_dw_lo",    {7'd0, done_write}, 8'h00);
    read = 1'b0;

    // Address extremes.
    write = 1'b1; address = 16'hFFFF; data_in = 8'h77;
    tick();
    address = 16'h0000; data_in = 8'h88;
    tick();
    write = 1'b0; read = 1'b1; address = 16'hFFFF;
    tick();
    chk("ext_top", data_out, 8'h77);
    address = 16'h0000;
    tick();
    chk("ext_bot", data_out, 8'h88);
    read = 1'b0;

    // Reset on the edge of the second write of a burst.
    write = 1'b1; address = 16'h3000; data_in = 8'h5A;
    tick();
    chk("mid_dw1", {7'd0, done_write}, 8'h01);
    address = 16'h3001; data_in = 8'hA5; RST = 1'b1;
    tick();
    chk("mid_dw2", {7'd0, done_write}, 8'h00);
    chk("mid_dout_rst", data_out, 8'h00);
    RST = 1'b0; write = 1'b0;
    tick();
    chk("mid_dw3", {7'd0, done_write}, 8'h00);
    read = 1'b1; address = 16'h3000;
    tick();
    chk("mid_first_kept", data_out, 8'h5A);
    address = 16'h3001;
    tick();
    chk("mid_second_drop", data_out, 8'hC3);
    read = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_dma_controller

`default_nettype wire

// File: doc/dma_controller.md
Name: dma_controller

Overview:
- Byte-wide RAM access engine with an internal byte-addressable memory.
- Sits between the file_handler front end (which splits 16-bit captured words into bytes) and the image buffer.
- Accepts one write or read request per clock and returns completion strobes.

Parameters:
- ADDR_W, 16, address width in bits; memory depth is 2**ADDR_W bytes.
- DATA_W, 8, data width in bits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- address  input  ADDR_W  byte address for the current request.
- data_in  input  DATA_W  byte to write.
- read  input  1  read request, level-sampled each rising edge.
- write  input  1  write request, level-sampled each rising edge.
- data_out  output  DATA_W  registered read data.
- done_read  output  1  read completion strobe.
- done_write  output  1  write completion strobe.

Behaviour:
- Reset: on a rising edge with RST=1, the following are all 0:
  - data_out, done_read, done_write
  - any internal pending/request registers.
- Memory contents are not cleared by reset and keep their prior values. No request is accepted while RST=1.
- A request is accepted only when its line is exactly 1. X, Z or 0 is treated as no request.
- Write:
  - Edge N with write=1: mem[address] <= data_in.
  - done_write=1 during cycle N+1, i.e. registered one cycle after acceptance.
- Read:
  - Edge N with read=1: data_out <= mem[address].
  - done_read=1 during cycle N+1, so data_out and done_read are valid together.
- Throughput:
  - One request of each type per cycle.
  - If write (or read) stays high for consecutive cycles, each cycle is a separate transfer at that cycle's address/data, and the done strobe stays high continuously.
  - This supports file_handler writing the high byte at ramBase and the low byte at ramBase+1 on back-to-back edges.
- Idle cycles: done strobes drop to 0 one cycle after the request line drops. data_out holds the last read value until the next read or reset.
- Simultaneous read and write:
  - Both are performed in the same cycle.
  - For the same address, the read returns the old (pre-write) byte (read-before-write).
  - Both done strobes assert in N+1.
- Address arithmetic: no wrap-around inside the block. Callers compute addresses, and address is used modulo 2**ADDR_W by width truncation.
- Reset mid-operation: a request accepted on the same edge as RST=1 is discarded, with no memory update and no done strobe. A done strobe due in the cycle after a reset edge is suppressed.
- Internal structure:
  - Request register stage: latched addr/data/read/write flags.
  - Memory array.
  - Output register stage.
  - No FSM beyond the IDLE/ACTIVE implied by the flags. An implementation may encode them as a 2-state FSM per channel.

Decomposition:
- Shared package (dma_pkg):
  - Default ADDR_W/DATA_W constants.
  - Byte and address typedefs.
- One natural sub-module: dma_byte_ram, a single-port-write/single-port-read synchronous byte RAM with read-before-write semantics.
- dma_controller wraps dma_byte_ram with request sampling and done-strobe generation.

Test Plan:
- Reset: hold RST=1 for 2 cycles with write=1, address=16'h0010, data_in=8'hAA. Expect done_write=0 and done_read=0 throughout. After release, a read of 16'h0010 shows the prior contents, not 8'hAA.
- Single write/read:
  - Write 8'h5C to 16'h0100; expect done_write=1 exactly one cycle later, then 0.
  - Read 16'h0100; next cycle expect done_read=1 and data_out=8'h5C.
- Back-to-back byte pair (file_handler pattern):
  - write held high; edge 1 writes 8'h12 at 16'h2000, edge 2 writes 8'h34 at 16'h2001.
  - done_write stays high for 2 cycles.
  - Reads return 8'h12 and 8'h34.
- Simultaneous read/write to the same address: mem[16'h0050]=8'h01; read=1 and write=1 with data_in=8'hFF. Expect data_out=8'h01 and both strobes high next cycle. A subsequent read returns 8'hFF.
- Address extremes: write 8'h77 at 16'hFFFF and 8'h88 at 16'h0000. Reads return each value independently, with no aliasing.
- Reset mid-burst: assert RST on the edge of the second write in a burst. That byte is not stored, done_write=0 the next cycle, and the first byte is retained.
